mvu_weight_sched: RTL and testbench

Weight-memory sequencer for one MVU instance. Per accepted input vector it walks the `SF*NF` weight words: `SF = MatrixW/SIMD` synapse folds run inner, and `NF = MatrixH/PE` neuron folds run outer. It drives the shared read address of all per-PE weight memories, which are synchronous with 1-cycle read latency and no enable. It also drives the activation-buffer chunk index. The block emits a control stream aligned with the registered memory output, so the PE array knows when to clear and when to emit its accumulators. Downstream backpressure freezes the stream without losing or duplicating a beat.

---
 rtl/mvu_pkg.sv | 29 ++
 rtl/mvu_fold_counter.sv | 29 ++
 rtl/mvu_weight_sched.sv | 131 +++++++++++++
 tb/tb_mvu_weight_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// rtl/mvu_pkg.sv - shared types and fold/width helpers for the MVU weight sequencer
package mvu_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mvu_sched_state_t;

    // Number of synapse folds: input columns consumed SIMD at a time.
    function automatic int sf_of(input int matrix_w, input int simd);
        return matrix_w / simd;
    endfunction

    // Number of neuron folds: output rows produced PE at a time.
    function automatic int nf_of(input int matrix_h, input int pe);
        return matrix_h / pe;
    endfunction

    // Width of an index over n values, never narrower than one bit.
    function automatic int cnt_bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Weight-memory address width; the memory and the sequencer both use this.
    function automatic int wmem_addr_bw(input int depth);
        return cnt_bw(depth);
    endfunction

endpackage

// File: rtl/mvu_fold_counter.sv
// rtl/mvu_fold_counter.sv - modulo counter with enable and terminal-count wrap flag
module mvu_fold_counter
    import mvu_pkg::*;
#(
    parameter int MOD = 4,
    parameter int W   = cnt_bw(MOD)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // wrap marks the terminal value so an outer counter can chain on it
    assign wrap = (count == LAST);

    // advance on enable, returning to zero after the terminal value
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/mvu_weight_sched.sv
// rtl/mvu_weight_sched.sv - weight-memory read sequencer and beat control stream for one MVU
module mvu_weight_sched
    import mvu_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int PE           = 2,
    parameter int MatrixW      = 8,
    parameter int MatrixH      = 4,
    parameter int WMEM_DEPTH   = sf_of(MatrixW, SIMD) * nf_of(MatrixH, PE),
    parameter int WMEM_ADDR_BW = wmem_addr_bw(WMEM_DEPTH),
    localparam int SF          = sf_of(MatrixW, SIMD),
    localparam int NF          = nf_of(MatrixH, PE),
    localparam int ACT_BW      = cnt_bw(SF),
    localparam int NF_BW       = cnt_bw(NF)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic                    stall,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic [ACT_BW-1:0]       act_idx,
    output logic                    w_valid,
    output logic                    w_sf_first,
    output logic                    w_sf_last,
    output logic                    w_vec_last
);

    if (MatrixW % SIMD != 0) begin : g_chk_matrix_w
        $error("MatrixW must be a multiple of SIMD");
    end
    if (MatrixH % PE != 0) begin : g_chk_matrix_h
        $error("MatrixH must be a multiple of PE");
    end
    if (WMEM_DEPTH != SF * NF) begin : g_chk_depth
        $error("WMEM_DEPTH must equal SF*NF");
    end

    mvu_sched_state_t state;
    mvu_sched_state_t state_next;

    logic [ACT_BW-1:0]       sf_cnt;
    logic                    sf_wrap;
    logic [NF_BW-1:0]        nf_cnt;
    logic                    nf_wrap;
    logic                    advance;
    logic                    last;
    logic [WMEM_ADDR_BW-1:0] issue_addr;
    logic [WMEM_ADDR_BW-1:0] data_addr;

    // synapse fold runs inner; its wrap carries into the neuron fold
    mvu_fold_counter #(
        .MOD (SF),
        .W   (ACT_BW)
    ) u_sf_cnt (
        .clock (clock),
        .reset (reset),
        .en    (advance),
        .count (sf_cnt),
        .wrap  (sf_wrap)
    );

    mvu_fold_counter #(
        .MOD (NF),
        .W   (NF_BW)
    ) u_nf_cnt (
        .clock (clock),
        .reset (reset),
        .en    (advance & sf_wrap),
        .count (nf_cnt),
        .wrap  (nf_wrap)
    );

    // folds are walked in address order, so nf*SF+sf steps by one and wraps with the vector
    assign issue_addr = WMEM_ADDR_BW'(int'(nf_cnt) * SF + int'(sf_cnt));

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state: a stalled cycle makes no progress; last beat chains into the next vector when one waits
    always_comb begin
        state_next = state;
        if (!stall) begin
            case (state)
                S_IDLE:  if (vec_valid) state_next = S_RUN;
                S_RUN:   if (last && !vec_valid) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // control outputs: acceptance window and counter advance
    always_comb begin
        last      = 1'b0;
        advance   = 1'b0;
        vec_ready = 1'b0;
        if (state == S_RUN) begin
            last    = sf_wrap & nf_wrap;
            advance = ~stall;
        end
        vec_ready = ~stall & ((state == S_IDLE) | last);
    end

    // beat pipeline follows the one-cycle memory read, frozen while downstream stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            w_valid    <= 1'b0;
            w_sf_first <= 1'b0;
            w_sf_last  <= 1'b0;
            w_vec_last <= 1'b0;
            data_addr  <= '0;
        end else if (!stall) begin
            w_valid    <= (state == S_RUN);
            w_sf_first <= (sf_cnt == '0);
            w_sf_last  <= sf_wrap;
            w_vec_last <= last;
            data_addr  <= issue_addr;
        end
    end

    // during a stall the memory re-reads the presented word so its output holds still
    assign wmem_addr = (stall && w_valid) ? data_addr : issue_addr;
    assign act_idx   = sf_cnt;

endmodule

// File: tb/tb_mvu_weight_sched.sv
// tb/tb_mvu_weight_sched.sv - self-checking bench for mvu_weight_sched
module tb_mvu_weight_sched;

    localparam int SF    = 4;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // main instance: SF=4, NF=2
    logic       vec_valid = 1'b0;
    logic       stall     = 1'b0;
    logic       vec_ready;
    logic [2:0] wmem_addr;
    logic [1:0] act_idx;
    logic       w_valid, w_sf_first, w_sf_last, w_vec_last;

    // second instance: SF=1, NF=2
    logic       vec_valid1 = 1'b0;
    logic       stall1     = 1'b0;
    logic       vec_ready1;
    logic [0:0] wmem_addr1;
    logic [0:0] act_idx1;
    logic       w_valid1, w_sf_first1, w_sf_last1, w_vec_last1;

    mvu_weight_sched #(
        .SIMD (2), .PE (2), .MatrixW (8), .MatrixH (4)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .stall      (stall),
        .wmem_addr  (wmem_addr),
        .act_idx    (act_idx),
        .w_valid    (w_valid),
        .w_sf_first (w_sf_first),
        .w_sf_last  (w_sf_last),
        .w_vec_last (w_vec_last)
    );

    mvu_weight_sched #(
        .SIMD (2), .PE (2), .MatrixW (2), .MatrixH (4)
    ) u_dut_sf1 (
        .clock      (clock),
        .reset      (reset),
        .vec_valid  (vec_valid1),
        .vec_ready  (vec_ready1),
        .stall      (stall1),
        .wmem_addr  (wmem_addr1),
        .act_idx    (act_idx1),
        .w_valid    (w_valid1),
        .w_sf_first (w_sf_first1),
        .w_sf_last  (w_sf_last1),
        .w_vec_last (w_vec_last1)
    );

    function automatic logic [7:0] word_of(input int a);
        return 8'(a * 37 + 5);
    endfunction

    // weight memory: synchronous read, one-cycle latency, no enable
    logic [7:0] wmem_out;
    always @(posedge clock) wmem_out <= word_of(int'(wmem_addr));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: queue of addresses still to issue plus the beat on the memory output
    int  pending[$];
    bit  beat_v   = 1'b0;
    int  beat_a   = 0;
    bit  model_ok = 1'b0;
    int  hs_cnt   = 0;
    int  vrun     = 0;
    int  vmax     = 0;

    always @(negedge clock) begin : compare
        bit run, lastc, e_ready;
        int issue, e_addr;
        run     = (pending.size() > 0);
        issue   = run ? pending[0] : 0;
        lastc   = run && (pending.size() == 1);
        e_ready = !stall && (!run || lastc);
        e_addr  = (stall && beat_v) ? beat_a : issue;
        if (model_ok) begin
            chk("m_vec_ready", int'(vec_ready), int'(e_ready));
            chk("m_wmem_addr", int'(wmem_addr), e_addr);
            chk("m_act_idx", int'(act_idx), issue % SF);
            chk("m_w_valid", int'(w_valid), int'(beat_v));
            if (beat_v) begin
                chk("m_sf_first", int'(w_sf_first), int'(beat_a % SF == 0));
                chk("m_sf_last", int'(w_sf_last), int'(beat_a % SF == SF - 1));
                chk("m_vec_last", int'(w_vec_last), int'(beat_a == DEPTH - 1));
                chk("m_wmem_out", int'(wmem_out), int'(word_of(beat_a)));
            end
            if (w_valid === 1'b1) begin
                vrun++;
                if (vrun > vmax) vmax = vrun;
            end else begin
                vrun = 0;
            end
        end
        if (reset) begin
            pending.delete();
            beat_v   = 1'b0;
            beat_a   = 0;
            model_ok = 1'b1;
        end else if (model_ok && !stall) begin
            beat_v = run;
            beat_a = issue;
            if (run) void'(pending.pop_front());
            if (vec_valid && e_ready) begin
                hs_cnt++;
                for (int i = 0; i < DEPTH; i++) pending.push_back(i);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin : stim
        int h0;
        logic [29:0] stall_pat;
        stall_pat = 30'b000110_0100_0001_1100_0000_1010_0010;

        cyc();
        cyc();
        reset = 1'b0;
        #2;
        chk("rst_w_valid", int'(w_valid), 0);
        chk("rst_wmem_addr", int'(wmem_addr), 0);
        chk("rst_act_idx", int'(act_idx), 0);
        chk("rst_vec_ready", int'(vec_ready), 1);
        chk("rst_flags", int'({w_sf_first, w_sf_last, w_vec_last}), 0);
        chk("rst_sf1_valid", int'(w_valid1), 0);
        repeat (3) cyc();

        // single vector
        vec_valid = 1'b1;
        #2;
        chk("sv_ready_c0", int'(vec_ready), 1);
        cyc();
        vec_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #2;
            case (c)
                1: begin
                    chk("sv_addr_c1", int'(wmem_addr), 0);
                    chk("sv_valid_c1", int'(w_valid), 0);
                    chk("sv_ready_c1", int'(vec_ready), 0);
                end
                2: begin
                    chk("sv_valid_c2", int'(w_valid), 1);
                    chk("sv_first_c2", int'(w_sf_first), 1);
                    chk("sv_addr_c2", int'(wmem_addr), 1);
                end
                5: chk("sv_sflast_b3", int'(w_sf_last), 1);
                6: chk("sv_first_b4", int'(w_sf_first), 1);
                8: begin
                    chk("sv_ready_c8", int'(vec_ready), 1);
                    chk("sv_addr_c8", int'(wmem_addr), 7);
                end
                9: begin
                    chk("sv_veclast_b7", int'(w_vec_last), 1);
                    chk("sv_sflast_b7", int'(w_sf_last), 1);
                end
                10: chk("sv_valid_c10", int'(w_valid), 0);
                default: ;
            endcase
            cyc();
        end
        repeat (2) cyc();

        // back-to-back vectors
        h0   = hs_cnt;
        vmax = 0;
        vec_valid = 1'b1;
        repeat (9) cyc();
        vec_valid = 1'b0;
        repeat (12) cyc();
        chk("b2b_handshakes", hs_cnt - h0, 2);
        chk("b2b_contig_beats", vmax, 16);

        // stall while beat address 2 is presented
        vec_valid = 1'b1;
        cyc();
        vec_valid = 1'b0;
        repeat (3) cyc();
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("st_addr_hold", int'(wmem_addr), 2);
            chk("st_valid_hold", int'(w_valid), 1);
            chk("st_out_hold", int'(wmem_out), int'(word_of(2)));
            chk("st_flags_hold", int'({w_sf_first, w_sf_last, w_vec_last}), 0);
            chk("st_ready", int'(vec_ready), 0);
            cyc();
        end
        stall = 1'b0;
        #2;
        chk("st_release_addr", int'(wmem_addr), 3);
        chk("st_release_out", int'(wmem_out), int'(word_of(2)));
        cyc();
        #2;
        chk("st_next_beat", int'(wmem_out), int'(word_of(3)));
        repeat (10) cyc();

        // reset while address 5 is issued
        vec_valid = 1'b1;
        cyc();
        vec_valid = 1'b0;
        repeat (5) cyc();
        #2;
        chk("rm_addr5", int'(wmem_addr), 5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        chk("rm_valid", int'(w_valid), 0);
        chk("rm_addr", int'(wmem_addr), 0);
        chk("rm_ready", int'(vec_ready), 1);
        repeat (3) cyc();

        // stall in IDLE blocks acceptance
        h0 = hs_cnt;
        stall = 1'b1;
        vec_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("is_ready_low", int'(vec_ready), 0);
            cyc();
        end
        stall = 1'b0;
        #2;
        chk("is_ready_high", int'(vec_ready), 1);
        cyc();
        vec_valid = 1'b0;
        #2;
        chk("is_addr0", int'(wmem_addr), 0);
        repeat (12) cyc();
        chk("is_handshakes", hs_cnt - h0, 1);

        // back-to-back traffic under a scattered stall pattern
        for (int c = 0; c < 30; c++) begin
            stall     = stall_pat[c];
            vec_valid = (c < 12);
            cyc();
        end
        stall = 1'b0;
        vec_valid = 1'b0;
        repeat (25) cyc();

        // SF=1 instance
        vec_valid1 = 1'b1;
        #2;
        chk("sf1_ready_c0", int'(vec_ready1), 1);
        cyc();
        vec_valid1 = 1'b0;
        #2;
        chk("sf1_addr_c1", int'(wmem_addr1), 0);
        chk("sf1_ready_c1", int'(vec_ready1), 0);
        cyc();
        #2;
        chk("sf1_addr_c2", int'(wmem_addr1), 1);
        chk("sf1_ready_c2", int'(vec_ready1), 1);
        chk("sf1_b0", int'({w_valid1, w_sf_first1, w_sf_last1, w_vec_last1}), 4'b1110);
        chk("sf1_act_idx", int'(act_idx1), 0);
        cyc();
        #2;
        chk("sf1_b1", int'({w_valid1, w_sf_first1, w_sf_last1, w_vec_last1}), 4'b1111);
        cyc();
        #2;
        chk("sf1_idle", int'(w_valid1), 0);
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
